// File: rtl/pcie_flow_ctrl_rx_init.sv
// Receive-side PCIe flow-control init: checks DLLP CRC16 on the link-layer RX stream,
// latches partner VC0 credit limits and raises the FC1/FC2 handshakes for the TX sequencer.

module pcie_datalink_crc (
   input  logic [15:0] crc_in,
   input  logic [31:0] data,
   output logic [15:0] crc_out
);
   // Polynomial 0x100B; data[0] enters first, so byte 0 is processed LSB first as on the wire.
   logic [15:0] crc;

   always_comb begin
      crc = crc_in;
      for (int i = 0; i < 32; i++) begin
         crc = {crc[14:0], 1'b0} ^ ((crc[15] ^ data[i]) ? 16'h100B : 16'h0000);
      end
      crc_out = crc;
   end
endmodule

module pcie_flow_ctrl_rx_init #(
   parameter int DATA_WIDTH    = 32,
   parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
   parameter int USER_WIDTH    = 3,
   parameter int ERR_CNT_WIDTH = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     link_up_i,
   input  logic [DATA_WIDTH-1:0]    s_axis_tdata,
   input  logic [KEEP_WIDTH-1:0]    s_axis_tkeep,
   input  logic                     s_axis_tvalid,
   input  logic                     s_axis_tlast,
   input  logic [USER_WIDTH-1:0]    s_axis_tuser,
   output logic                     s_axis_tready,
   output logic                     fc1_values_stored_o,
   output logic                     fc2_values_stored_o,
   output logic [7:0]               p_hdr_cl_o,
   output logic [7:0]               np_hdr_cl_o,
   output logic [7:0]               cpl_hdr_cl_o,
   output logic [11:0]              p_data_cl_o,
   output logic [11:0]              np_data_cl_o,
   output logic [11:0]              cpl_data_cl_o,
   output logic                     update_fc_o,
   output logic                     crc_err_o,
   output logic [ERR_CNT_WIDTH-1:0] crc_err_cnt_o
);

   typedef enum logic [1:0] {
      ST_HDR,
      ST_CRC,
      ST_DROP,
      ST_DROP_DONE
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] dllp_q;
   logic [2:0]  seen_q;
   logic        hdr_load;
   logic        eval;
   logic        beat;

   logic [15:0] crc_calc;
   logic [7:0]  dllp_type;
   logic [7:0]  rx_hdr;
   logic [11:0] rx_data;
   logic [1:0]  fc_sel;
   logic        crc_ok;
   logic        good_vc0;
   logic        wr_credit;
   logic        set_fc2;
   logic        unused_bits;

   assign beat = s_axis_tvalid && s_axis_tready;

   // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_HDR;
         dllp_q  <= '0;
      end else begin
         state_q <= state_d;
         if (hdr_load) dllp_q <= s_axis_tdata[31:0];
      end
   end

   // NOTE: every output of this block is defaulted first so no path can infer a latch.
   always_comb begin
      state_d  = state_q;
      hdr_load = 1'b0;
      eval     = 1'b0;
      if (!link_up_i) begin
         state_d = ST_HDR;
      end else begin
         unique case (state_q)
            ST_HDR: begin
               if (beat) begin
                  hdr_load = 1'b1;
                  if (s_axis_tlast || (s_axis_tkeep != {KEEP_WIDTH{1'b1}})) state_d = ST_DROP_DONE;
                  else                                                      state_d = ST_CRC;
               end
            end
            ST_CRC: begin
               if (beat) begin
                  if (!s_axis_tlast) begin
                     state_d = ST_DROP;
                  end else begin
                     eval    = 1'b1;
                     state_d = ST_HDR;
                  end
               end
            end
            ST_DROP: begin
               if (beat && s_axis_tlast) state_d = ST_HDR;
            end
            ST_DROP_DONE: state_d = ST_HDR;
            default:      state_d = ST_HDR;
         endcase
      end
   end

   pcie_datalink_crc u_crc (
      .crc_in  (16'hFFFF),
      .data    (dllp_q),
      .crc_out (crc_calc)
   );

   assign dllp_type = dllp_q[7:0];
   assign rx_hdr    = {dllp_q[13:8], dllp_q[23:22]};
   assign rx_data   = {dllp_q[19:16], dllp_q[31:24]};
   assign fc_sel    = dllp_type[5:4];
   assign crc_ok    = (s_axis_tdata[15:0] == ~crc_calc);

   // Type[7:6]: 01 InitFC1, 10 UpdateFC, 11 InitFC2; type[5:4] selects P/NP/Cpl.
   assign good_vc0  = eval && crc_ok && (dllp_type[3:0] == 4'h0) && (fc_sel != 2'b11)
                      && (dllp_type[7:6] != 2'b00);
   assign wr_credit = good_vc0 && ((dllp_type[7:6] == 2'b10) ||
                                   ((dllp_type[7:6] == 2'b01) && !fc2_values_stored_o));
   assign set_fc2   = good_vc0 && fc1_values_stored_o && dllp_type[7];

   assign unused_bits = ^{s_axis_tuser, dllp_q[15:14], dllp_q[21:20]};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s_axis_tready       <= 1'b0;
         seen_q              <= '0;
         fc1_values_stored_o <= 1'b0;
         fc2_values_stored_o <= 1'b0;
         p_hdr_cl_o          <= '0;
         np_hdr_cl_o         <= '0;
         cpl_hdr_cl_o        <= '0;
         p_data_cl_o         <= '0;
         np_data_cl_o        <= '0;
         cpl_data_cl_o       <= '0;
         update_fc_o         <= 1'b0;
         crc_err_o           <= 1'b0;
         crc_err_cnt_o       <= '0;
      end else begin
         s_axis_tready <= 1'b1;
         update_fc_o   <= 1'b0;
         crc_err_o     <= 1'b0;
         if (!link_up_i) begin
            // Error counter survives link-down; everything learned from the partner does not.
            seen_q              <= '0;
            fc1_values_stored_o <= 1'b0;
            fc2_values_stored_o <= 1'b0;
            p_hdr_cl_o          <= '0;
            np_hdr_cl_o         <= '0;
            cpl_hdr_cl_o        <= '0;
            p_data_cl_o         <= '0;
            np_data_cl_o        <= '0;
            cpl_data_cl_o       <= '0;
         end else begin
            fc1_values_stored_o <= &seen_q;
            if (eval && !crc_ok) begin
               crc_err_o <= 1'b1;
               if (crc_err_cnt_o != {ERR_CNT_WIDTH{1'b1}})
                  crc_err_cnt_o <= crc_err_cnt_o + ERR_CNT_WIDTH'(1);
            end
            if (wr_credit) begin
               unique case (fc_sel)
                  2'b00:   begin p_hdr_cl_o   <= rx_hdr; p_data_cl_o   <= rx_data; end
                  2'b01:   begin np_hdr_cl_o  <= rx_hdr; np_data_cl_o  <= rx_data; end
                  default: begin cpl_hdr_cl_o <= rx_hdr; cpl_data_cl_o <= rx_data; end
               endcase
               if (!dllp_type[7]) seen_q[fc_sel] <= 1'b1;
               else               update_fc_o    <= 1'b1;
            end
            if (set_fc2) fc2_values_stored_o <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pcie_flow_ctrl_rx_init.sv
// Directed bench for pcie_flow_ctrl_rx_init: FC init handshakes, CRC errors, malformed
// framing, error-counter saturation, link-down and asynchronous reset.

module tb_pcie_flow_ctrl_rx_init;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        link_up_i;
   logic [31:0] s_axis_tdata;
   logic [3:0]  s_axis_tkeep;
   logic        s_axis_tvalid;
   logic        s_axis_tlast;
   logic [2:0]  s_axis_tuser;
   logic        s_axis_tready;
   logic        fc1_values_stored_o;
   logic        fc2_values_stored_o;
   logic [7:0]  p_hdr_cl_o, np_hdr_cl_o, cpl_hdr_cl_o;
   logic [11:0] p_data_cl_o, np_data_cl_o, cpl_data_cl_o;
   logic        update_fc_o;
   logic        crc_err_o;
   logic [7:0]  crc_err_cnt_o;
   logic [59:0] limits;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk_i = ~clk_i;

   assign limits = {p_hdr_cl_o, p_data_cl_o, np_hdr_cl_o, np_data_cl_o, cpl_hdr_cl_o, cpl_data_cl_o};

   pcie_flow_ctrl_rx_init dut (
      .clk_i               (clk_i),
      .rst_ni              (rst_ni),
      .link_up_i           (link_up_i),
      .s_axis_tdata        (s_axis_tdata),
      .s_axis_tkeep        (s_axis_tkeep),
      .s_axis_tvalid       (s_axis_tvalid),
      .s_axis_tlast        (s_axis_tlast),
      .s_axis_tuser        (s_axis_tuser),
      .s_axis_tready       (s_axis_tready),
      .fc1_values_stored_o (fc1_values_stored_o),
      .fc2_values_stored_o (fc2_values_stored_o),
      .p_hdr_cl_o          (p_hdr_cl_o),
      .np_hdr_cl_o         (np_hdr_cl_o),
      .cpl_hdr_cl_o        (cpl_hdr_cl_o),
      .p_data_cl_o         (p_data_cl_o),
      .np_data_cl_o        (np_data_cl_o),
      .cpl_data_cl_o       (cpl_data_cl_o),
      .update_fc_o         (update_fc_o),
      .crc_err_o           (crc_err_o),
      .crc_err_cnt_o       (crc_err_cnt_o)
   );

   // Byte-wise MSB-first formulation of the CRC16 (poly 0x100B), each byte bit-reversed on entry.
   function automatic logic [15:0] crc16(input logic [31:0] w);
      logic [15:0] c;
      logic [7:0]  byt;
      logic [7:0]  rev;
      c = 16'hFFFF;
      for (int b = 0; b < 4; b++) begin
         byt = w[8*b +: 8];
         for (int k = 0; k < 8; k++) rev[k] = byt[7-k];
         c = c ^ {rev, 8'h00};
         for (int k = 0; k < 8; k++) c = c[15] ? ({c[14:0], 1'b0} ^ 16'h100B) : {c[14:0], 1'b0};
      end
      return c;
   endfunction

   function automatic logic [31:0] mk_word(input logic [7:0] t, input logic [7:0] h, input logic [11:0] d);
      logic [31:0] w;
      w        = '0;
      w[7:0]   = t;
      w[13:8]  = h[7:2];
      w[23:22] = h[1:0];
      w[19:16] = d[11:8];
      w[31:24] = d[7:0];
      return w;
   endfunction

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
      s_axis_tdata  = d;
      s_axis_tkeep  = k;
      s_axis_tlast  = l;
      s_axis_tvalid = 1'b1;
      tick();
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
   endtask

   // Returns just after the beat-1 edge, when the registered action is visible.
   task automatic send_dllp(input logic [7:0] t, input logic [7:0] h, input logic [11:0] d,
                            input logic [15:0] flip);
      logic [31:0] w;
      w = mk_word(t, h, d);
      send_beat(w, 4'hF, 1'b0);
      send_beat({16'h0000, ~crc16(w) ^ flip}, 4'h3, 1'b1);
   endtask

   task automatic link_drop();
      link_up_i = 1'b0;
      tick();
      link_up_i = 1'b1;
   endtask

   task automatic test_reset();
      rst_ni = 1'b1; link_up_i = 1'b1; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
      s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tuser = 3'b101;
      #2 rst_ni = 1'b0;
      #1;
      n_checks++;
      if (s_axis_tready !== 1'b0) begin
         n_fail++; $display("FAIL reset_tready: got %b want 0", s_axis_tready);
      end
      repeat (3) @(posedge clk_i);
      #1 rst_ni = 1'b1;
      tick();
      n_checks++;
      if (s_axis_tready !== 1'b1) begin
         n_fail++; $display("FAIL tready_after_reset: got %b want 1", s_axis_tready);
      end
      n_checks++;
      if ({fc1_values_stored_o, fc2_values_stored_o, update_fc_o, crc_err_o, crc_err_cnt_o, limits} !== 72'h0) begin
         n_fail++;
         $display("FAIL reset_outputs: flags %b%b%b%b cnt %h limits %h want all 0",
                  fc1_values_stored_o, fc2_values_stored_o, update_fc_o, crc_err_o, crc_err_cnt_o, limits);
      end
   endtask

   task automatic test_init_fc1();
      send_dllp(8'h40, 8'h20, 12'h010, 16'h0);
      send_dllp(8'h50, 8'h20, 12'h020, 16'h0);
      send_dllp(8'h60, 8'h00, 12'h000, 16'h0);
      n_checks++;
      if (fc1_values_stored_o !== 1'b0) begin
         n_fail++; $display("FAIL fc1_not_yet: got %b want 0", fc1_values_stored_o);
      end
      tick();
      n_checks++;
      if (fc1_values_stored_o !== 1'b1) begin
         n_fail++; $display("FAIL fc1_rise: got %b want 1", fc1_values_stored_o);
      end
      n_checks++;
      if (limits !== {8'h20, 12'h010, 8'h20, 12'h020, 8'h00, 12'h000}) begin
         n_fail++; $display("FAIL fc1_limits: got %h want %h", limits, {8'h20, 12'h010, 8'h20, 12'h020, 8'h00, 12'h000});
      end
      n_checks++;
      if ({crc_err_cnt_o, fc2_values_stored_o} !== 9'h0) begin
         n_fail++; $display("FAIL fc1_no_err: cnt %h fc2 %b want 0 0", crc_err_cnt_o, fc2_values_stored_o);
      end
   endtask

   task automatic test_crc_error();
      link_drop();
      n_checks++;
      if ({fc1_values_stored_o, limits} !== 61'h0) begin
         n_fail++; $display("FAIL linkdown_clear: fc1 %b limits %h want 0", fc1_values_stored_o, limits);
      end
      send_dllp(8'h40, 8'h20, 12'h010, 16'h0);
      send_dllp(8'h50, 8'h20, 12'h020, 16'h0001);
      n_checks++;
      if ({crc_err_o, crc_err_cnt_o} !== {1'b1, 8'h01}) begin
         n_fail++; $display("FAIL crc_err_pulse: err %b cnt %h want 1 01", crc_err_o, crc_err_cnt_o);
      end
      tick();
      n_checks++;
      if (crc_err_o !== 1'b0) begin
         n_fail++; $display("FAIL crc_err_one_cycle: got %b want 0", crc_err_o);
      end
      send_dllp(8'h60, 8'h00, 12'h000, 16'h0);
      tick();
      n_checks++;
      if ({fc1_values_stored_o, np_hdr_cl_o, np_data_cl_o} !== 21'h0) begin
         n_fail++; $display("FAIL bad_np_not_stored: fc1 %b np %h/%h want 0 00/000",
                            fc1_values_stored_o, np_hdr_cl_o, np_data_cl_o);
      end
      send_dllp(8'h50, 8'h20, 12'h020, 16'h0);
      tick();
      n_checks++;
      if ({fc1_values_stored_o, np_hdr_cl_o, np_data_cl_o} !== {1'b1, 8'h20, 12'h020}) begin
         n_fail++; $display("FAIL np_resend: fc1 %b np %h/%h want 1 20/020",
                            fc1_values_stored_o, np_hdr_cl_o, np_data_cl_o);
      end
   endtask

   task automatic test_fc2();
      link_drop();
      send_dllp(8'h40, 8'h20, 12'h010, 16'h0);
      send_dllp(8'h50, 8'h20, 12'h020, 16'h0);
      send_dllp(8'hC0, 8'h20, 12'h010, 16'h0);
      tick();
      n_checks++;
      if (fc2_values_stored_o !== 1'b0) begin
         n_fail++; $display("FAIL fc2_before_fc1: got %b want 0", fc2_values_stored_o);
      end
      send_dllp(8'h60, 8'h00, 12'h000, 16'h0);
      tick();
      send_dllp(8'hD0, 8'h77, 12'h777, 16'h0);
      n_checks++;
      if ({fc2_values_stored_o, np_hdr_cl_o, np_data_cl_o} !== {1'b1, 8'h20, 12'h020}) begin
         n_fail++; $display("FAIL fc2_set: fc2 %b np %h/%h want 1 20/020",
                            fc2_values_stored_o, np_hdr_cl_o, np_data_cl_o);
      end
      send_dllp(8'h40, 8'h33, 12'h055, 16'h0);
      n_checks++;
      if ({p_hdr_cl_o, p_data_cl_o} !== {8'h20, 12'h010}) begin
         n_fail++; $display("FAIL fc1_after_fc2_ignored: got %h/%h want 20/010", p_hdr_cl_o, p_data_cl_o);
      end
   endtask

   task automatic test_update_fc();
      link_drop();
      send_dllp(8'h40, 8'h20, 12'h010, 16'h0);
      send_dllp(8'h50, 8'h20, 12'h020, 16'h0);
      send_dllp(8'h60, 8'h00, 12'h000, 16'h0);
      tick();
      send_dllp(8'hA0, 8'h40, 12'h100, 16'h0);
      n_checks++;
      if ({update_fc_o, fc2_values_stored_o, cpl_hdr_cl_o, cpl_data_cl_o} !== {1'b1, 1'b1, 8'h40, 12'h100}) begin
         n_fail++; $display("FAIL update_fc: upd %b fc2 %b cpl %h/%h want 1 1 40/100",
                            update_fc_o, fc2_values_stored_o, cpl_hdr_cl_o, cpl_data_cl_o);
      end
      tick();
      n_checks++;
      if (update_fc_o !== 1'b0) begin
         n_fail++; $display("FAIL update_fc_one_cycle: got %b want 0", update_fc_o);
      end
   endtask

   task automatic test_malformed();
      logic [31:0] w;
      link_drop();
      w = mk_word(8'h40, 8'h5A, 12'h0A5);
      send_beat(w, 4'hF, 1'b0);
      send_beat({16'h0, ~crc16(w)}, 4'h3, 1'b0);
      send_beat(32'h0, 4'h3, 1'b1);
      tick();
      n_checks++;
      if ({crc_err_o, p_hdr_cl_o, p_data_cl_o} !== 21'h0) begin
         n_fail++; $display("FAIL three_beat_drop: err %b p %h/%h want 0 00/000", crc_err_o, p_hdr_cl_o, p_data_cl_o);
      end
      send_beat(w, 4'hF, 1'b1);
      tick();
      send_dllp(8'h40, 8'h11, 12'h022, 16'h0);
      n_checks++;
      if ({crc_err_o, crc_err_cnt_o, p_hdr_cl_o, p_data_cl_o} !== {1'b0, 8'h01, 8'h11, 12'h022}) begin
         n_fail++; $display("FAIL after_malformed: err %b cnt %h p %h/%h want 0 01 11/022",
                            crc_err_o, crc_err_cnt_o, p_hdr_cl_o, p_data_cl_o);
      end
      send_dllp(8'h51, 8'h44, 12'h055, 16'h0);
      n_checks++;
      if ({crc_err_o, np_hdr_cl_o, np_data_cl_o} !== 21'h0) begin
         n_fail++; $display("FAIL vc1_ignored: err %b np %h/%h want 0 00/000", crc_err_o, np_hdr_cl_o, np_data_cl_o);
      end
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 300; i++) send_dllp(8'h40, 8'h01, 12'h001, 16'h8000);
      n_checks++;
      if ({crc_err_o, crc_err_cnt_o} !== {1'b1, 8'hFF}) begin
         n_fail++; $display("FAIL cnt_saturate: err %b cnt %h want 1 ff", crc_err_o, crc_err_cnt_o);
      end
      send_dllp(8'h40, 8'h20, 12'h010, 16'h0);
      send_dllp(8'h50, 8'h20, 12'h020, 16'h0);
      send_dllp(8'h60, 8'h00, 12'h000, 16'h0);
      tick();
      send_dllp(8'h80, 8'h05, 12'h006, 16'h0);
      n_checks++;
      if ({fc1_values_stored_o, fc2_values_stored_o, p_hdr_cl_o, p_data_cl_o} !== {2'b11, 8'h05, 12'h006}) begin
         n_fail++; $display("FAIL pre_linkdown: fc1 %b fc2 %b p %h/%h want 1 1 05/006",
                            fc1_values_stored_o, fc2_values_stored_o, p_hdr_cl_o, p_data_cl_o);
      end
      link_drop();
      n_checks++;
      if ({fc1_values_stored_o, fc2_values_stored_o, limits, crc_err_cnt_o} !== {62'h0, 8'hFF}) begin
         n_fail++; $display("FAIL linkdown_keeps_cnt: fc1 %b fc2 %b limits %h cnt %h want 0 0 0 ff",
                            fc1_values_stored_o, fc2_values_stored_o, limits, crc_err_cnt_o);
      end
   endtask

   task automatic test_reset_mid();
      send_beat(mk_word(8'h40, 8'h22, 12'h033), 4'hF, 1'b0);
      #2 rst_ni = 1'b0;
      #1;
      n_checks++;
      if ({s_axis_tready, fc1_values_stored_o, fc2_values_stored_o, crc_err_cnt_o, limits} !== 71'h0) begin
         n_fail++; $display("FAIL async_reset: rdy %b fc1 %b fc2 %b cnt %h limits %h want all 0",
                            s_axis_tready, fc1_values_stored_o, fc2_values_stored_o, crc_err_cnt_o, limits);
      end
      @(posedge clk_i);
      #1 rst_ni = 1'b1;
      tick();
      send_dllp(8'h50, 8'h09, 12'h00A, 16'h0);
      n_checks++;
      if ({crc_err_o, np_hdr_cl_o, np_data_cl_o, p_hdr_cl_o} !== {1'b0, 8'h09, 12'h00A, 8'h00}) begin
         n_fail++; $display("FAIL post_reset_decode: err %b np %h/%h p_hdr %h want 0 09/00a 00",
                            crc_err_o, np_hdr_cl_o, np_data_cl_o, p_hdr_cl_o);
      end
   endtask

   initial begin
      #200_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_init_fc1();
      test_crc_error();
      test_fc2();
      test_update_fc();
      test_malformed();
      test_saturation();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pcie_flow_ctrl_rx_init.md
Name: pcie_flow_ctrl_rx_init

Overview:
- Receive-side companion to the transmit flow-control init sequencer.
- Consumes DLLPs from the link-layer RX AXI-stream and checks their CRC16. Decodes InitFC1, InitFC2 and UpdateFC DLLPs for VC0.
- Latches the partner's header/data credit limits per type (P, NP, Cpl).
- Produces the fc1_values_stored / fc2_values_stored handshakes consumed by the TX sequencer.

Parameters:
- DATA_WIDTH, 32, stream data width; only 32 is supported.
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width.
- USER_WIDTH, 3, tuser width; the value is ignored.
- ERR_CNT_WIDTH, 8, width of the saturating CRC-error counter.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous assert, active-low
- link_up_i  in  1  DL active; 0 clears all stored state synchronously
- s_axis_tdata  in  DATA_WIDTH  DLLP beats
- s_axis_tkeep  in  KEEP_WIDTH  byte enables
- s_axis_tvalid  in  1  beat valid
- s_axis_tlast  in  1  last beat
- s_axis_tuser  in  USER_WIDTH  ignored
- s_axis_tready  out  1  always 1 out of reset
- fc1_values_stored_o  out  1  InitFC1 P, NP and Cpl all received
- fc2_values_stored_o  out  1  FC_INIT2 complete
- p_hdr_cl_o, np_hdr_cl_o, cpl_hdr_cl_o  out  8 each  header credit limits
- p_data_cl_o, np_data_cl_o, cpl_data_cl_o  out  12 each  data credit limits
- update_fc_o  out  1  one-cycle pulse on each accepted UpdateFC
- crc_err_o  out  1  one-cycle pulse on a CRC mismatch
- crc_err_cnt_o  out  ERR_CNT_WIDTH  saturating count of CRC mismatches

Behaviour:
- Reset: all outputs 0 (s_axis_tready 0 while rst_ni low, then 1); state ST_HDR.
- DLLP framing: two beats.
  - Beat 0: tkeep 4'hF. tdata[7:0] = type.
  - Beat 0 header field: HdrFC[7:2] = tdata[13:8], HdrFC[1:0] = tdata[23:22].
  - Beat 0 data field: DataFC[11:8] = tdata[19:16], DataFC[7:0] = tdata[31:24].
  - Beat 0: tdata[7:0] bits [2:0] are the VC ID; scale bits are ignored.
  - Beat 1: tkeep 4'h3, tlast 1, tdata[15:0] = received CRC.
- CRC: pcie_datalink_crc instance with crcIn = 16'hFFFF, data = registered beat-0 word. Match condition: beat1 tdata[15:0] == bytewise-inverted computed CRC.
- FSM states:
  - ST_HDR: on a valid beat, register the word. tlast=1 or tkeep!=4'hF → ST_DROP_DONE (discard, no error pulse). Otherwise → ST_CRC.
  - ST_CRC: on a valid beat: tlast=0 → ST_DROP. tlast=1 → evaluate the CRC, act, → ST_HDR.
  - ST_DROP: consume beats until tlast, then → ST_HDR.
  - ST_DROP_DONE: → ST_HDR without consuming.
- On CRC mismatch: crc_err_o pulses the cycle after the beat-1 handshake. crc_err_cnt_o increments and saturates at all-ones. Nothing is stored.
- On CRC match, VC ID != 0: ignored.
- On CRC match, VC0, the registered action is visible the cycle after the beat-1 handshake:
  - InitFC1 types 0x40 (P), 0x50 (NP), 0x60 (Cpl): update the matching credit-limit pair and set the seen bit for that type. Update only while fc2_values_stored_o=0.
  - InitFC2 types 0xC0 / 0xD0 / 0xE0: ignored unless fc1_values_stored_o=1, in which case set fc2_values_stored_o. Credit values are not re-latched.
  - UpdateFC types 0x80 / 0x90 / 0xA0: overwrite the matching pair and pulse update_fc_o. If fc1_values_stored_o=1, also set fc2_values_stored_o.
  - Any other type: ignored.
- fc1_values_stored_o = all three seen bits set; registered, so it rises the cycle after the completing DLLP's effect.
- fc2_values_stored_o is sticky until link_up_i=0 or reset.
- A credit value of 0 means infinite credits; it is stored verbatim.
- Duplicate InitFC1 before FC2: the latest value wins.
- link_up_i=0: clear seen bits, both stored flags, all credit limits and the FSM (→ ST_HDR). The error counter is retained. Beats are still accepted and dropped.
- Reset mid-packet: FSM returns to ST_HDR and the partial DLLP is lost.

Test Plan:
- Good InitFC1 P (hdr 0x20, data 0x010), then NP (0x20/0x020), then Cpl (0x00/0x000). Expect fc1_values_stored_o rising the cycle after the Cpl beat 1. Expect p_hdr_cl_o=0x20, p_data_cl_o=0x010, cpl_*=0.
- The same sequence with the NP CRC corrupted (bit 0 flipped). Expect a crc_err_o pulse, crc_err_cnt_o=1, fc1 stays 0. Resending NP sets fc1.
- InitFC2_P before fc1 → no fc2. After fc1, InitFC2_NP → fc2_values_stored_o=1. A subsequent InitFC1_P with new values leaves the limits unchanged.
- After fc1, UpdateFC_Cpl hdr 0x40, data 0x100 → update_fc_o one-cycle pulse, cpl limits updated, fc2 set.
- Malformed traffic: a 3-beat packet, then a 1-beat tlast packet. Both are dropped, no error, and the next good DLLP decodes correctly. A VC1 InitFC1 is ignored.
- 300 bad-CRC DLLPs → crc_err_cnt_o saturates at 0xFF. link_up_i low for 1 cycle clears flags and limits but not the counter. rst_ni low mid-DLLP clears everything asynchronously.
